// File: rtl/pll_reconfig_ctrl.sv
// PLL power-on / reconfiguration sequencer with lock supervision.
// Drives the reconfig Avalon-MM port and retries a failed lock once.
module pll_reconfig_ctrl #(
  parameter int LOCK_TIMEOUT = 1000000,
  parameter int RST_CYCLES   = 16,
  parameter int FRAC         = 1
) (
  input  logic        refclk,
  input  logic        rst,
  input  logic        cfg_req,
  input  logic [7:0]  cfg_n,
  input  logic [7:0]  cfg_m,
  input  logic [7:0]  cfg_c0,
  input  logic [31:0] cfg_k,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_err,
  output logic [5:0]  mgmt_address,
  output logic        mgmt_write,
  output logic [31:0] mgmt_writedata,
  input  logic        mgmt_waitrequest,
  input  logic        pll_locked,
  output logic        pll_rst,
  output logic        locked_sync
);

  localparam int CW = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [CW-1:0] LT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] RS_LAST = CW'(RST_CYCLES - 1);

  typedef enum logic [3:0] {
    PORST, IDLE, W_MODE, W_N, W_M, W_C0,
    W_K, W_START, WAIT_LOCK, RETRY_RST
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [10:0]   r_hi;
  logic          r_seen_low;
  logic          r_retry;
  logic [7:0]    r_n;
  logic [7:0]    r_m;
  logic [7:0]    r_c0;
  logic [31:0]   r_k;
  logic          r_done;
  logic          r_err;
  logic          r_sync1;
  logic          r_sync2;

  logic w_wr_ok;
  logic w_cfg_ok;
  logic w_qual;
  logic w_lt;
  logic w_rs;

  function automatic logic [31:0] f_div(input logic [7:0] d);
    logic [8:0] up;
    up = {1'b0, d} + 9'd1;
    if (d == 8'd1) return 32'h0001_0000;
    return {14'd0, d[0], 1'b0, up[8:1], 1'b0, d[7:1]};
  endfunction

  assign w_wr_ok  = mgmt_write & ~mgmt_waitrequest;
  assign w_cfg_ok = (|cfg_n) & (|cfg_m) & (|cfg_c0);
  assign w_lt     = (r_cnt == LT_LAST);
  assign w_rs     = (r_cnt == RS_LAST);
  // a lock already present on entry only counts after 1024 stable cycles
  assign w_qual   = r_sync2 &
                    ((r_seen_low & (r_hi == 11'd15)) |
                     (r_hi == 11'd1023));

  assign cfg_done    = r_done;
  assign cfg_err     = r_err;
  assign locked_sync = r_sync2;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      PORST:     if (w_rs) w_next = WAIT_LOCK;
      IDLE:      if (cfg_req && w_cfg_ok) w_next = W_MODE;
      W_MODE:    if (w_wr_ok) w_next = W_N;
      W_N:       if (w_wr_ok) w_next = W_M;
      W_M:       if (w_wr_ok) w_next = W_C0;
      W_C0:      if (w_wr_ok) w_next = (FRAC != 0) ? W_K : W_START;
      W_K:       if (w_wr_ok) w_next = W_START;
      W_START:   if (w_wr_ok) w_next = WAIT_LOCK;
      WAIT_LOCK: begin
        if (w_qual) w_next = IDLE;
        else if (w_lt) w_next = r_retry ? IDLE : RETRY_RST;
      end
      RETRY_RST: if (w_rs) w_next = WAIT_LOCK;
      default:   w_next = PORST;
    endcase
  end

  always_comb begin
    mgmt_write     = 1'b0;
    mgmt_address   = 6'd0;
    mgmt_writedata = 32'd0;
    pll_rst        = 1'b0;
    cfg_busy       = 1'b1;
    unique case (r_state)
      PORST, RETRY_RST: pll_rst = 1'b1;
      IDLE:   cfg_busy = 1'b0;
      W_MODE: mgmt_write = 1'b1;
      W_N: begin
        mgmt_write     = 1'b1;
        mgmt_address   = 6'd3;
        mgmt_writedata = f_div(r_n);
      end
      W_M: begin
        mgmt_write     = 1'b1;
        mgmt_address   = 6'd4;
        mgmt_writedata = f_div(r_m);
      end
      // counter index 0 in [22:18] leaves the divider word unchanged
      W_C0: begin
        mgmt_write     = 1'b1;
        mgmt_address   = 6'd5;
        mgmt_writedata = f_div(r_c0);
      end
      W_K: begin
        mgmt_write     = 1'b1;
        mgmt_address   = 6'd7;
        mgmt_writedata = r_k;
      end
      W_START: begin
        mgmt_write     = 1'b1;
        mgmt_address   = 6'd2;
        mgmt_writedata = 32'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_state    <= PORST;
      r_cnt      <= '0;
      r_hi       <= '0;
      r_seen_low <= 1'b0;
      r_retry    <= 1'b0;
      r_n        <= '0;
      r_m        <= '0;
      r_c0       <= '0;
      r_k        <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
    end else begin
      r_sync1 <= pll_locked;
      r_sync2 <= r_sync1;
      r_state <= w_next;
      r_done  <= (r_state == WAIT_LOCK) && w_qual;

      if (w_next != r_state) r_cnt <= '0;
      else if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;

      if (r_state != WAIT_LOCK) begin
        r_hi       <= '0;
        r_seen_low <= 1'b0;
      end else if (r_sync2) begin
        if (r_hi != '1) r_hi <= r_hi + 1'b1;
      end else begin
        r_hi       <= '0;
        r_seen_low <= 1'b1;
      end

      if (r_state == PORST || r_state == RETRY_RST)
        r_retry <= 1'b1;
      else if (r_state == IDLE && cfg_req)
        r_retry <= 1'b0;

      if (r_state == IDLE && cfg_req) begin
        r_n   <= cfg_n;
        r_m   <= cfg_m;
        r_c0  <= cfg_c0;
        r_k   <= cfg_k;
        r_err <= ~w_cfg_ok;
      end else if (r_state == WAIT_LOCK && !w_qual && w_lt && r_retry) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule
